pc_flow_controller: RTL and testbench
=====================================

# pc_flow_controller

Sequencing controller for the 32-bit program-counter register and fetch stage. It decodes control-flow events (JMP, CALL, RET, RTI, external interrupt) into the PC register's select lines `jumpSignal`, `interruptSignal` and `RetRtiCall`. It runs the multi-cycle interrupt-entry and return sequences, and drives fetch stall/flush and stack push/pop strobes. It sits between the decode stage, the write-back stage and the PC register.

## Interface

- `MAX_WAIT`, default 15: cycles allowed in WAIT_WB before a timeout is declared (1..15).
- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `InstrValid`  in  1  decode-stage instruction valid.
- `IsJump`  in  1  decoded jump taken (target on PC `Rdst`); qualified by `InstrValid`.
- `IsCall`  in  1  decoded CALL; qualified by `InstrValid`.
- `IsRet`  in  1  decoded RET; qualified by `InstrValid`.
- `IsRti`  in  1  decoded RTI; qualified by `InstrValid`.
- `Intr`  in  1  external interrupt request, level.
- `WbPcValid`  in  1  write-back presents the new PC (call target or popped PC) on the PC register's write-back data input.
- `JumpSel`  out  1  drives PC `jumpSignal`.
- `IntSel`  out  1  drives PC `interruptSignal`.
- `RetSel`  out  1  drives PC `RetRtiCall`.
- `Stall`  out  1  fetch holds the current PC (PC `InData` = PC).
- `Flush`  out  1  IF/ID register loads a NOP.
- `PushPc`  out  1  stack unit pushes the current PC.
- `PushFlags`  out  1  stack unit pushes the flags.
- `PopFlags`  out  1  stack unit pops the flags.
- `TimeoutErr`  out  1  sticky; set on WAIT_WB timeout.
- `State`  out  3  current FSM state encoding, for debug.

## Operation

- States and encodings:
  - IDLE = 0
  - INT_PUSH_PC = 1
  - INT_PUSH_FLAGS = 2
  - INT_VECTOR = 3
  - WAIT_WB = 4
  - RTI_FLAGS = 5
- Registers:
  - state
  - `op_rti` flag
  - `int_pending` flag
  - 4-bit `wait_cnt`
  - `TimeoutErr`
- `int_pending` is set on any cycle with `Intr`=1. It is cleared on entry to INT_PUSH_PC.
- IDLE decode priority, with `ctl` = `InstrValid` & (`IsJump`|`IsCall`|`IsRet`|`IsRti`):
  1. `IsJump`: `JumpSel`=1 and `Flush`=1 this cycle (Mealy). Stay in IDLE.
  2. `IsCall` / `IsRet` / `IsRti`, in that order: `Flush`=1 this cycle, go to WAIT_WB, set `op_rti` = (`IsRti` & !`IsCall` & !`IsRet`), clear `wait_cnt`.
  3. If `ctl`=0 and (`Intr` | `int_pending`): go to INT_PUSH_PC.
  4. Otherwise all outputs are 0.
- A control-flow op always wins over an interrupt. The interrupt stays pending and is taken on the first IDLE cycle with `ctl`=0.
- Multiple op bits set at once is illegal. The priority above resolves it deterministically.
- INT_PUSH_PC: `Stall`=1, `Flush`=1, `PushPc`=1. Next state INT_PUSH_FLAGS.
- INT_PUSH_FLAGS: `Stall`=1, `Flush`=1, `PushFlags`=1. Next state INT_VECTOR.
- INT_VECTOR: `IntSel`=1, `Flush`=1. Next state IDLE.
- WAIT_WB: `Stall`=1, `Flush`=1.
  - On `WbPcValid`=1: `RetSel`=1 this cycle (Mealy), `Stall`=0. Next state is RTI_FLAGS if `op_rti`, else IDLE.
  - Else `wait_cnt` increments. At `wait_cnt` = `MAX_WAIT`-1 with no `WbPcValid`: `TimeoutErr` is set, next state IDLE, no `RetSel`.
- RTI_FLAGS: `PopFlags`=1, `Flush`=1. Next state IDLE.
- `Intr` during any non-IDLE state only sets `int_pending`. It never aborts a sequence.
- `JumpSel`, `IntSel` and `RetSel` are mutually exclusive in every cycle.
- `TimeoutErr` clears only on `Rst`.

## Timing

- Reset: on any cycle with `Rst`=1, every output is 0 and `State`=0.
  - The next edge loads state=IDLE and clears `int_pending`, `op_rti`, `wait_cnt` and `TimeoutErr`.
  - `Rst` mid-sequence (e.g. in WAIT_WB) abandons the sequence and does not assert `RetSel`.
- Jump latency: `IsJump` in cycle T means `JumpSel`=1 in T, and the PC holds `Rdst` after edge T.
- Interrupt latency: `Intr` first high in IDLE cycle T with `ctl`=0 gives:
  - T+1 INT_PUSH_PC
  - T+2 INT_PUSH_FLAGS
  - T+3 INT_VECTOR, with `IntSel`=1; PC = 0 after edge T+3
  - T+4 IDLE
- Return latency: RET in T gives WAIT_WB from T+1. `WbPcValid` in cycle T+k gives `RetSel`=1 in T+k, and PC = write-back data after that edge.
  - RTI adds RTI_FLAGS in T+k+1.
- Minimum WAIT_WB residence is 1 cycle; maximum is `MAX_WAIT` cycles.
- `WbPcValid` outside WAIT_WB is ignored.

## Test plan

- Reset then idle: hold `Rst` 2 cycles, then 5 cycles with no inputs -> all outputs 0, `State`=0, PC register stays at 32.
- Jump: `InstrValid`=`IsJump`=1 in one cycle -> `JumpSel`=1 and `Flush`=1 that cycle only; `State` stays 0.
- Interrupt entry: `Intr` pulse 1 cycle in IDLE -> `PushPc` at T+1, `PushFlags` at T+2, `IntSel` at T+3, `Stall` high T+1..T+2, PC = 0 after T+3.
- RTI with `WbPcValid` 3 cycles after decode -> `State` 4 for 3 cycles, `RetSel`=1 exactly once, then `PopFlags`=1 for 1 cycle, then IDLE.
- Collision: `Intr` and `IsCall` in the same IDLE cycle, `WbPcValid` 2 cycles later -> CALL completes first (`RetSel`), then the interrupt sequence starts on the next IDLE cycle with `ctl`=0.
- Timeout and reset: RET with no `WbPcValid` and `MAX_WAIT`=15 -> `TimeoutErr`=1 after 15 WAIT_WB cycles, then IDLE. Separately, `Rst` asserted in WAIT_WB -> IDLE and no `RetSel`; `TimeoutErr` is 0 after the reset edge.

Source files
------------

// File: rtl/pc_flow_controller.sv
// Program-counter sequencing controller: decodes JMP/CALL/RET/RTI/interrupt into
// PC select lines and runs the interrupt-entry and write-back return sequences.
module pc_flow_controller #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       InstrValid,
  input  logic       IsJump,
  input  logic       IsCall,
  input  logic       IsRet,
  input  logic       IsRti,
  input  logic       Intr,
  input  logic       WbPcValid,
  output logic       JumpSel,
  output logic       IntSel,
  output logic       RetSel,
  output logic       Stall,
  output logic       Flush,
  output logic       PushPc,
  output logic       PushFlags,
  output logic       PopFlags,
  output logic       TimeoutErr,
  output logic [2:0] State
);

  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] INT_PUSH_PC    = 3'd1;
  localparam logic [2:0] INT_PUSH_FLAGS = 3'd2;
  localparam logic [2:0] INT_VECTOR     = 3'd3;
  localparam logic [2:0] WAIT_WB        = 3'd4;
  localparam logic [2:0] RTI_FLAGS      = 3'd5;

  localparam logic [3:0] LAST_CNT = 4'(MAX_WAIT - 1);

  logic [2:0] state, nextState;
  logic       opRti, intPending, timeoutReg;
  logic [3:0] waitCnt;

  logic jumpC, intC, retC, stallC, flushC, pushPcC, pushFlagsC, popFlagsC;
  logic startWait, incWait, setTimeout;

  always_comb begin
    nextState  = state;
    jumpC      = 1'b0;
    intC       = 1'b0;
    retC       = 1'b0;
    stallC     = 1'b0;
    flushC     = 1'b0;
    pushPcC    = 1'b0;
    pushFlagsC = 1'b0;
    popFlagsC  = 1'b0;
    startWait  = 1'b0;
    incWait    = 1'b0;
    setTimeout = 1'b0;
    case (state)
      IDLE: begin
        if (InstrValid && IsJump) begin
          jumpC  = 1'b1;
          flushC = 1'b1;
        end else if (InstrValid && (IsCall || IsRet || IsRti)) begin
          flushC    = 1'b1;
          startWait = 1'b1;
          nextState = WAIT_WB;
        end else if (Intr || intPending) begin
          nextState = INT_PUSH_PC;
        end
      end
      INT_PUSH_PC: begin
        stallC    = 1'b1;
        flushC    = 1'b1;
        pushPcC   = 1'b1;
        nextState = INT_PUSH_FLAGS;
      end
      INT_PUSH_FLAGS: begin
        stallC     = 1'b1;
        flushC     = 1'b1;
        pushFlagsC = 1'b1;
        nextState  = INT_VECTOR;
      end
      INT_VECTOR: begin
        intC      = 1'b1;
        flushC    = 1'b1;
        nextState = IDLE;
      end
      WAIT_WB: begin
        flushC = 1'b1;
        if (WbPcValid) begin
          retC      = 1'b1;
          nextState = opRti ? RTI_FLAGS : IDLE;
        end else begin
          stallC = 1'b1;
          if (waitCnt == LAST_CNT) begin
            setTimeout = 1'b1;
            nextState  = IDLE;
          end else begin
            incWait = 1'b1;
          end
        end
      end
      RTI_FLAGS: begin
        popFlagsC = 1'b1;
        flushC    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      opRti      <= 1'b0;
      intPending <= 1'b0;
      waitCnt    <= '0;
      timeoutReg <= 1'b0;
    end else begin
      state <= nextState;
      // Entering INT_PUSH_PC consumes the request; a still-high level re-arms it afterwards.
      if (state == IDLE && nextState == INT_PUSH_PC)
        intPending <= 1'b0;
      else if (Intr)
        intPending <= 1'b1;
      if (startWait) begin
        opRti   <= IsRti & ~IsCall & ~IsRet;
        waitCnt <= '0;
      end else if (incWait) begin
        waitCnt <= waitCnt + 4'd1;
      end
      if (setTimeout)
        timeoutReg <= 1'b1;
    end
  end

  // Reset forces every output low in the same cycle, abandoning any pending RetSel.
  assign JumpSel    = ~Rst & jumpC;
  assign IntSel     = ~Rst & intC;
  assign RetSel     = ~Rst & retC;
  assign Stall      = ~Rst & stallC;
  assign Flush      = ~Rst & flushC;
  assign PushPc     = ~Rst & pushPcC;
  assign PushFlags  = ~Rst & pushFlagsC;
  assign PopFlags   = ~Rst & popFlagsC;
  assign TimeoutErr = ~Rst & timeoutReg;
  assign State      = Rst ? '0 : state;

endmodule

// File: tb/tb_pc_flow_controller.sv
// Directed bench for pc_flow_controller: one output snapshot checked per cycle
// against hand-derived vectors.
module tb_pc_flow_controller;

  logic Clk, Rst, InstrValid, IsJump, IsCall, IsRet, IsRti, Intr, WbPcValid;
  logic JumpSel, IntSel, RetSel, Stall, Flush, PushPc, PushFlags, PopFlags, TimeoutErr;
  logic [2:0] State;

  int unsigned nChecks = 0;
  int unsigned nFail   = 0;

  pc_flow_controller #(.MAX_WAIT(15)) dut (
    .Clk(Clk), .Rst(Rst), .InstrValid(InstrValid), .IsJump(IsJump), .IsCall(IsCall),
    .IsRet(IsRet), .IsRti(IsRti), .Intr(Intr), .WbPcValid(WbPcValid),
    .JumpSel(JumpSel), .IntSel(IntSel), .RetSel(RetSel), .Stall(Stall), .Flush(Flush),
    .PushPc(PushPc), .PushFlags(PushFlags), .PopFlags(PopFlags),
    .TimeoutErr(TimeoutErr), .State(State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {State, JumpSel, IntSel, RetSel, Stall, Flush, PushPc, PushFlags, PopFlags, TimeoutErr}
  logic [11:0] obs;
  assign obs = {State, JumpSel, IntSel, RetSel, Stall, Flush, PushPc, PushFlags, PopFlags, TimeoutErr};

  localparam logic [8:0] J  = 9'h100;
  localparam logic [8:0] I  = 9'h080;
  localparam logic [8:0] R  = 9'h040;
  localparam logic [8:0] S  = 9'h020;
  localparam logic [8:0] F  = 9'h010;
  localparam logic [8:0] PP = 9'h008;
  localparam logic [8:0] PF = 9'h004;
  localparam logic [8:0] PO = 9'h002;
  localparam logic [8:0] TO = 9'h001;
  localparam logic [8:0] Z  = 9'h000;

  // Check on the falling edge, then advance to just after the next rising edge.
  task automatic chk(input string tag, input logic [11:0] exp);
    @(negedge Clk);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic clearIn();
    InstrValid = 0; IsJump = 0; IsCall = 0; IsRet = 0; IsRti = 0; Intr = 0; WbPcValid = 0;
  endtask

  initial begin
    clearIn();
    Rst = 1;
    chk("reset0", {3'd0, Z});
    chk("reset1", {3'd0, Z});
    Rst = 0;
    for (int i = 0; i < 5; i++) chk("idle", {3'd0, Z});

    // Jump: single-cycle Mealy JumpSel/Flush
    InstrValid = 1; IsJump = 1;
    chk("jump", {3'd0, J | F});
    clearIn();
    chk("jump_after", {3'd0, Z});

    // Interrupt entry from a one-cycle pulse
    Intr = 1;
    chk("intr_T", {3'd0, Z});
    clearIn();
    chk("intr_T1", {3'd1, S | F | PP});
    chk("intr_T2", {3'd2, S | F | PF});
    chk("intr_T3", {3'd3, I | F});
    chk("intr_T4", {3'd0, Z});

    // RTI, write-back arrives in the third WAIT_WB cycle
    InstrValid = 1; IsRti = 1;
    chk("rti_dec", {3'd0, F});
    clearIn();
    chk("rti_w1", {3'd4, S | F});
    chk("rti_w2", {3'd4, S | F});
    WbPcValid = 1;
    chk("rti_wb", {3'd4, R | F});
    WbPcValid = 0;
    chk("rti_pop", {3'd5, PO | F});
    chk("rti_idle", {3'd0, Z});

    // Write-back valid outside WAIT_WB is ignored
    WbPcValid = 1;
    chk("wb_ignored", {3'd0, Z});
    WbPcValid = 0;

    // Collision: CALL wins, interrupt taken on the next ctl-free IDLE cycle
    InstrValid = 1; IsCall = 1; Intr = 1;
    chk("col_dec", {3'd0, F});
    clearIn();
    chk("col_w1", {3'd4, S | F});
    WbPcValid = 1;
    chk("col_wb", {3'd4, R | F});
    WbPcValid = 0;
    chk("col_idle", {3'd0, Z});
    chk("col_pushpc", {3'd1, S | F | PP});
    chk("col_pushfl", {3'd2, S | F | PF});
    chk("col_vector", {3'd3, I | F});
    chk("col_done", {3'd0, Z});

    // Timeout: RET with no write-back, 15 WAIT_WB cycles
    InstrValid = 1; IsRet = 1;
    chk("to_dec", {3'd0, F});
    clearIn();
    for (int i = 0; i < 15; i++) chk("to_wait", {3'd4, S | F});
    chk("to_err", {3'd0, TO});
    chk("to_sticky", {3'd0, TO});

    // Reset inside WAIT_WB with write-back pending: no RetSel, error cleared
    InstrValid = 1; IsRet = 1;
    chk("rst_dec", {3'd0, F | TO});
    clearIn();
    chk("rst_w1", {3'd4, S | F | TO});
    Rst = 1; WbPcValid = 1;
    chk("rst_mid", {3'd0, Z});
    Rst = 0; WbPcValid = 0;
    chk("rst_after", {3'd0, Z});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
